// File: rtl/funcion_conf_pkg.sv
// Shared constants for the configuration-mode controller and the register
// chip-select decoder: one-hot funcion_conf codes and FSM state encoding.
package funcion_conf_pkg;

    localparam logic [2:0] FC_IDLE  = 3'b000;
    localparam logic [2:0] FC_HORA  = 3'b001;
    localparam logic [2:0] FC_FECHA = 3'b010;
    localparam logic [2:0] FC_TIMER = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONF   = 2'd1,
        ST_COMMIT = 2'd2
    } estado_t;

    // Simultaneous requests resolve hora > fecha > timer.
    function automatic logic [2:0] sel_codigo(input logic hora, input logic fecha,
                                              input logic timer);
        if (hora)
            return FC_HORA;
        else if (fecha)
            return FC_FECHA;
        else if (timer)
            return FC_TIMER;
        return FC_IDLE;
    endfunction

endpackage

// File: rtl/generador_funcion_conf_contador.sv
// Inactivity counter for configuration mode; exists only when
// INACTIVIDAD_TIMEOUT_EN is defined. Saturates at TIMEOUT_CICLOS-1.
`ifdef INACTIVIDAD_TIMEOUT_EN
module contador_inactividad #(
    parameter int unsigned TIMEOUT_CICLOS = 1_000_000_000,
    parameter int          CONT_W         = 30
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CONT_W-1:0] LIMITE = CONT_W'(TIMEOUT_CICLOS - 1);

    logic [CONT_W-1:0] cnt_q;

    assign expired = (cnt_q == LIMITE);

    always_ff @(posedge clk) begin
        if (!reset)
            cnt_q <= '0;
        else if (clear)
            cnt_q <= '0;
        else if (enable && !expired)
            cnt_q <= cnt_q + 1'b1;
    end

endmodule
`endif

// File: rtl/generador_funcion_conf.sv
// Configuration-mode controller: button pulses -> one-hot funcion_conf, with
// RTC commit handshake. Inactivity abort built only with INACTIVIDAD_TIMEOUT_EN.
module generador_funcion_conf
    import funcion_conf_pkg::*;
#(
    parameter int unsigned TIMEOUT_CICLOS = 1_000_000_000,
    parameter int          CONT_W         = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_conf_hora,
    input  logic       btn_conf_fecha,
    input  logic       btn_conf_timer,
    input  logic       btn_salir,
    input  logic       actividad,
    input  logic       rtc_busy,
    input  logic       rtc_ack,
    output logic [2:0] funcion_conf,
    output logic       conf_activa,
    output logic       escribir_rtc,
    output logic       cancelado
);

    estado_t    estado_q, estado_d;
    logic [2:0] codigo_d;
    logic [2:0] fc_d;
    logic       activa_d, escribir_d;
    logic       btn_conf_any;
    logic       timeout;

    assign btn_conf_any = btn_conf_hora | btn_conf_fecha | btn_conf_timer;

`ifdef INACTIVIDAD_TIMEOUT_EN
    logic clr_cnt, expirado, cancel_d, cancel_q;

    // Any button in CONF counts as activity; outside CONF the count is held at 0.
    assign clr_cnt = (estado_q != ST_CONF) | actividad | btn_conf_any | btn_salir;
    assign timeout = expirado & ~clr_cnt;

    contador_inactividad #(
        .TIMEOUT_CICLOS(TIMEOUT_CICLOS),
        .CONT_W        (CONT_W)
    ) u_contador (
        .clk    (clk),
        .reset  (reset),
        .clear  (clr_cnt),
        .enable (estado_q == ST_CONF),
        .expired(expirado)
    );

    assign cancel_d  = (estado_q == ST_CONF) && (estado_d == ST_IDLE);
    assign cancelado = cancel_q;

    always_ff @(posedge clk) begin
        if (!reset)
            cancel_q <= 1'b0;
        else
            cancel_q <= cancel_d;
    end
`else
    logic unused_cfg;

    // Timeout parameters and activity only matter when the abort is built.
    assign unused_cfg = ^{TIMEOUT_CICLOS[0], CONT_W[0], actividad};
    assign timeout    = 1'b0;
    assign cancelado  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado_q     <= ST_IDLE;
            funcion_conf <= FC_IDLE;
            conf_activa  <= 1'b0;
            escribir_rtc <= 1'b0;
        end else begin
            estado_q     <= estado_d;
            funcion_conf <= fc_d;
            conf_activa  <= activa_d;
            escribir_rtc <= escribir_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        codigo_d = funcion_conf;
        case (estado_q)
            ST_IDLE: begin
                if (!rtc_busy && btn_conf_any) begin
                    estado_d = ST_CONF;
                    codigo_d = sel_codigo(btn_conf_hora, btn_conf_fecha, btn_conf_timer);
                end
            end
            ST_CONF: begin
                if (btn_salir)
                    estado_d = ST_COMMIT;
                else if (timeout)
                    estado_d = ST_IDLE;
            end
            ST_COMMIT: begin
                if (rtc_ack)
                    estado_d = ST_IDLE;
            end
            default: estado_d = ST_IDLE;
        endcase
    end

    // Code stays on the bus through COMMIT so chip selects remain valid.
    always_comb begin
        fc_d       = (estado_d == ST_IDLE) ? FC_IDLE : codigo_d;
        activa_d   = (estado_d != ST_IDLE);
        escribir_d = (estado_d == ST_COMMIT);
    end

endmodule

// File: tb/tb_generador_funcion_conf.sv
// Self-checking bench for generador_funcion_conf: directed scenarios plus
// randomized traffic against a cycle-level behavioural model.
module tb_generador_funcion_conf;

    localparam int unsigned TO = 16;
`ifdef INACTIVIDAD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_conf_hora = 1'b0, btn_conf_fecha = 1'b0, btn_conf_timer = 1'b0;
    logic       btn_salir = 1'b0, actividad = 1'b0, rtc_busy = 1'b0, rtc_ack = 1'b0;
    logic [2:0] funcion_conf;
    logic       conf_activa, escribir_rtc, cancelado;

    int errors = 0;
    int checks = 0;

    // model: mode 0 idle, 1 editing, 2 waiting for RTC
    int         m_mode = 0;
    int         m_idle = 0;
    logic [2:0] m_code = 3'b000;
    logic [2:0] e_fc = 3'b000;
    logic       e_act = 1'b0, e_wr = 1'b0, e_can = 1'b0;

    generador_funcion_conf #(.TIMEOUT_CICLOS(TO), .CONT_W(5)) dut (
        .clk(clk), .reset(reset),
        .btn_conf_hora(btn_conf_hora), .btn_conf_fecha(btn_conf_fecha),
        .btn_conf_timer(btn_conf_timer), .btn_salir(btn_salir),
        .actividad(actividad), .rtc_busy(rtc_busy), .rtc_ack(rtc_ack),
        .funcion_conf(funcion_conf), .conf_activa(conf_activa),
        .escribir_rtc(escribir_rtc), .cancelado(cancelado)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        logic any;
        any = actividad | btn_conf_hora | btn_conf_fecha | btn_conf_timer | btn_salir;
        e_can = 1'b0;
        if (!reset) begin
            m_mode = 0;
            m_code = 3'b000;
            m_idle = 0;
        end else if (m_mode == 0) begin
            if (!rtc_busy && (btn_conf_hora || btn_conf_fecha || btn_conf_timer)) begin
                m_mode = 1;
                m_idle = 0;
                m_code = btn_conf_hora ? 3'b001 : (btn_conf_fecha ? 3'b010 : 3'b100);
            end
        end else if (m_mode == 1) begin
            if (btn_salir)
                m_mode = 2;
            else if (TO_EN && !any && m_idle == int'(TO) - 1) begin
                m_mode = 0;
                e_can  = 1'b1;
            end else
                m_idle = any ? 0 : m_idle + 1;
        end else if (rtc_ack) begin
            m_mode = 0;
        end
        e_fc  = (m_mode == 0) ? 3'b000 : m_code;
        e_act = (m_mode != 0);
        e_wr  = (m_mode == 2);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic clear_inputs();
        btn_conf_hora = 0; btn_conf_fecha = 0; btn_conf_timer = 0;
        btn_salir = 0; actividad = 0; rtc_ack = 0; rtc_busy = 0;
    endtask

    task automatic go_idle();
        clear_inputs();
        btn_salir = 1; tick(); btn_salir = 0;
        tick();
        rtc_ack = 1; tick(); rtc_ack = 0;
        tick();
    endtask

    task automatic test_reset();
        reset = 0;
        btn_conf_hora = 1; btn_conf_fecha = 1; btn_conf_timer = 1;
        btn_salir = 1; actividad = 1; rtc_ack = 1;
        tick(); tick();
        checks++;
        if ({funcion_conf, conf_activa, escribir_rtc, cancelado} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=000000",
                     {funcion_conf, conf_activa, escribir_rtc, cancelado});
        end
        clear_inputs();
        reset = 1;
        for (int i = 0; i < 4; i++) tick();
        btn_conf_fecha = 1; tick(); btn_conf_fecha = 0;
        checks++;
        if (funcion_conf !== 3'b010 || conf_activa !== 1'b1) begin
            errors++;
            $display("FAIL enter_fecha got fc=%b act=%b exp fc=010 act=1", funcion_conf, conf_activa);
        end
    endtask

    task automatic test_priority();
        go_idle();
        btn_conf_hora = 1; btn_conf_timer = 1; tick();
        btn_conf_hora = 0; btn_conf_timer = 0;
        checks++;
        if (funcion_conf !== 3'b001) begin
            errors++;
            $display("FAIL prio_hora_timer got=%b exp=001", funcion_conf);
        end
        tick(); btn_conf_timer = 1; tick(); btn_conf_timer = 0; tick();
        checks++;
        if (funcion_conf !== 3'b001 || conf_activa !== 1'b1) begin
            errors++;
            $display("FAIL no_switch_in_conf got fc=%b act=%b exp fc=001 act=1", funcion_conf, conf_activa);
        end
    endtask

    task automatic test_commit();
        int bad;
        go_idle();
        btn_conf_timer = 1; tick(); btn_conf_timer = 0;
        btn_salir = 1; tick(); btn_salir = 0;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (escribir_rtc !== 1'b1 || funcion_conf !== 3'b100 || conf_activa !== 1'b1) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL commit_hold bad_cycles=%0d exp=0", bad);
        end
        rtc_ack = 1; tick(); rtc_ack = 0;
        checks++;
        if (escribir_rtc !== 1'b0 || funcion_conf !== 3'b000 || conf_activa !== 1'b0) begin
            errors++;
            $display("FAIL commit_ack got wr=%b fc=%b act=%b exp wr=0 fc=000 act=0",
                     escribir_rtc, funcion_conf, conf_activa);
        end
    endtask

    task automatic test_timeout();
        int bad;
        int cans;
        go_idle();
        btn_conf_hora = 1; tick(); btn_conf_hora = 0;
        bad = 0;
        for (int i = 1; i < int'(TO); i++) begin
            tick();
            if (funcion_conf !== 3'b001 || cancelado !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL timeout_early bad_cycles=%0d exp=0", bad);
        end
        tick();
        checks++;
        if (funcion_conf !== (TO_EN ? 3'b000 : 3'b001) || cancelado !== TO_EN) begin
            errors++;
            $display("FAIL timeout_abort got fc=%b can=%b exp fc=%b can=%b",
                     funcion_conf, cancelado, TO_EN ? 3'b000 : 3'b001, TO_EN);
        end
        tick();
        checks++;
        if (cancelado !== 1'b0) begin
            errors++;
            $display("FAIL cancel_one_cycle got=%b exp=0", cancelado);
        end
        go_idle();
        btn_conf_hora = 1; tick(); btn_conf_hora = 0;
        cans = 0;
        for (int i = 0; i < 100; i++) begin
            actividad = (i % 10 == 9);
            tick();
            if (cancelado !== 1'b0 || funcion_conf !== 3'b001) cans++;
        end
        actividad = 0;
        checks++;
        if (cans != 0) begin
            errors++;
            $display("FAIL activity_keeps_conf bad_cycles=%0d exp=0", cans);
        end
    endtask

    task automatic test_busy();
        go_idle();
        rtc_busy = 1; btn_conf_hora = 1; tick(); btn_conf_hora = 0;
        checks++;
        if (funcion_conf !== 3'b000 || conf_activa !== 1'b0) begin
            errors++;
            $display("FAIL busy_ignored got fc=%b act=%b exp fc=000 act=0", funcion_conf, conf_activa);
        end
        rtc_busy = 0; tick(); tick(); tick();
        checks++;
        if (funcion_conf !== 3'b000) begin
            errors++;
            $display("FAIL busy_not_queued got=%b exp=000", funcion_conf);
        end
    endtask

    task automatic test_reset_commit();
        go_idle();
        btn_conf_fecha = 1; tick(); btn_conf_fecha = 0;
        btn_salir = 1; tick(); btn_salir = 0;
        tick(); tick();
        reset = 0; tick(); reset = 1;
        checks++;
        if (escribir_rtc !== 1'b0 || funcion_conf !== 3'b000 || conf_activa !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_commit got wr=%b fc=%b act=%b exp wr=0 fc=000 act=0",
                     escribir_rtc, funcion_conf, conf_activa);
        end
        rtc_ack = 1; tick(); rtc_ack = 0; tick();
        checks++;
        if (escribir_rtc !== 1'b0 || funcion_conf !== 3'b000 || conf_activa !== 1'b0) begin
            errors++;
            $display("FAIL late_ack got wr=%b fc=%b act=%b exp wr=0 fc=000 act=0",
                     escribir_rtc, funcion_conf, conf_activa);
        end
    endtask

    task automatic test_random();
        int shown;
        shown = 0;
        for (int i = 0; i < 600; i++) begin
            reset          = ($urandom_range(0, 149) != 0);
            btn_conf_hora  = ($urandom_range(0, 9) == 0);
            btn_conf_fecha = ($urandom_range(0, 9) == 0);
            btn_conf_timer = ($urandom_range(0, 9) == 0);
            btn_salir      = ($urandom_range(0, 29) == 0);
            actividad      = ($urandom_range(0, 24) == 0);
            rtc_busy       = ($urandom_range(0, 3) == 0);
            rtc_ack        = ($urandom_range(0, 5) == 0);
            tick();
            checks++;
            if (funcion_conf !== e_fc || conf_activa !== e_act ||
                escribir_rtc !== e_wr || cancelado !== e_can) begin
                errors++;
                if (shown < 10)
                    $display("FAIL random cyc=%0d got fc=%b act=%b wr=%b can=%b exp fc=%b act=%b wr=%b can=%b",
                             i, funcion_conf, conf_activa, escribir_rtc, cancelado,
                             e_fc, e_act, e_wr, e_can);
                shown++;
            end
        end
        clear_inputs();
        reset = 1;
    endtask

    initial begin
        test_reset();
        test_priority();
        test_commit();
        test_timeout();
        test_busy();
        test_reset_commit();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/generador_funcion_conf.md
Name: generador_funcion_conf

Overview:
- Configuration-mode controller. Turns debounced user button pulses into the 3-bit one-hot funcion_conf code consumed by the register chip-select decoder.
- Holds the selected mode while the user edits the registers.
- On exit, sequences a commit handshake with the RTC write controller.
- Sits between the push-button debouncers and the hora/fecha/timer register bank.

Parameters:
- TIMEOUT_CICLOS, 1_000_000_000, inactivity cycles in CONF before the mode is aborted (10 s at 100 MHz).
- CONT_W, 30, width of the inactivity counter; must satisfy 2^CONT_W > TIMEOUT_CICLOS.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- btn_conf_hora  input  1  one-cycle pulse, request time configuration.
- btn_conf_fecha  input  1  one-cycle pulse, request date configuration.
- btn_conf_timer  input  1  one-cycle pulse, request timer configuration.
- btn_salir  input  1  one-cycle pulse, leave configuration and commit.
- actividad  input  1  any edit button pulse (up/down/left/right); restarts the inactivity count.
- rtc_busy  input  1  RTC write controller is occupied.
- rtc_ack  input  1  one-cycle pulse, commit accepted by the RTC write controller.
- funcion_conf  output  3  000 idle, 001 hora, 010 fecha, 100 timer.
- conf_activa  output  1  high in CONF and COMMIT.
- escribir_rtc  output  1  commit request, level.
- cancelado  output  1  one-cycle pulse on inactivity abort.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, on port reset. All outputs are registered.
- Reset (reset=0 at a clk edge): state IDLE, funcion_conf=000, conf_activa=0, escribir_rtc=0, cancelado=0, counter=0. Reset wins over every other input, including in the middle of COMMIT; no ack is awaited afterwards.
- funcion_conf is only ever 000, 001, 010 or 100. Codes 011, 101, 110 and 111 are never driven.
- IDLE:
  - funcion_conf=000.
  - If rtc_busy=0 and any conf button is high: go to CONF next cycle with the matching code. Latency is 1 cycle from pulse to code.
  - Simultaneous requests: priority hora > fecha > timer.
  - rtc_busy=1: conf buttons are ignored (not queued).
  - btn_salir and actividad are ignored.
- CONF:
  - Code held, conf_activa=1.
  - The counter increments each cycle. It clears on entry and on any of actividad, conf button or btn_salir.
  - Further conf buttons are ignored; the mode cannot be switched without exiting.
  - btn_salir -> COMMIT next cycle.
  - Counter reaches TIMEOUT_CICLOS-1 with no activity -> IDLE next cycle, funcion_conf=000, cancelado=1 for exactly that one cycle.
  - btn_salir wins over timeout in the same cycle.
- COMMIT:
  - escribir_rtc=1. funcion_conf is still held so the chip selects stay valid during the write.
  - Waits indefinitely for rtc_ack. All buttons are ignored.
  - rtc_ack -> IDLE next cycle: escribir_rtc=0, funcion_conf=000, conf_activa=0.
  - rtc_ack outside COMMIT is ignored.
- Counter saturates and never wraps; it is held at 0 outside CONF.

Optional Feature:
- Macro: INACTIVIDAD_TIMEOUT_EN.
- Defined: the inactivity counter, the timeout abort and the cancelado pulse exist as described above.
- Undefined: no counter is synthesized, CONF is left only via btn_salir, and cancelado is tied to 0. TIMEOUT_CICLOS and CONT_W are unused.

Decomposition:
- Shared package (funcion_conf_pkg):
  - Code localparams FC_IDLE=3'b000, FC_HORA=3'b001, FC_FECHA=3'b010, FC_TIMER=3'b100. The chip-select decoder uses the same constants.
  - State encoding ST_IDLE, ST_CONF, ST_COMMIT (2 bits).
- Sub-module contador_inactividad: clear / enable / expired output, present only under INACTIVIDAD_TIMEOUT_EN.
- The FSM and output registers stay in the top.

Test Plan:
- Reset with all buttons high -> all outputs 0. Release, btn_conf_fecha pulse at cycle 5 -> funcion_conf=010 and conf_activa=1 from cycle 6.
- IDLE, btn_conf_hora and btn_conf_timer in the same cycle -> funcion_conf=001. A later btn_conf_timer in CONF leaves the code at 001.
- In 100, btn_salir -> escribir_rtc=1 and funcion_conf=100 held for 20 cycles. rtc_ack -> next cycle escribir_rtc=0, funcion_conf=000.
- TIMEOUT_CICLOS=16, macro defined: enter 001 with no activity -> 16 cycles later funcion_conf=000 and cancelado=1 for 1 cycle. Repeat with an actividad pulse every 10 cycles -> no abort after 100 cycles.
- rtc_busy=1 plus btn_conf_hora -> stays 000. rtc_busy drops, no new pulse -> stays 000.
- reset=0 asserted mid-COMMIT -> next cycle escribir_rtc=0, funcion_conf=000. A late rtc_ack in IDLE has no effect.
